pe_readout_scanner: RTL and testbench

PE_READOUT_SCANNER -- requirements
Module: pe_readout_scanner

---
 rtl/pe_readout_scanner_if.sv | 24 ++
 rtl/pe_readout_scanner.sv | 114 +++++++++++
 tb/tb_pe_readout_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pe_readout_scanner_if.sv
// Show-ahead readout stream: head entry plus its source PE index.
// The master presents the head; the slave accepts on valid && ready.
interface pe_readout_scanner_if #(
    parameter int SIZE = 5
);
    logic [15:0]     out_data;
    logic [SIZE-1:0] out_pe;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output out_data,
        output out_pe,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_pe,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pe_readout_scanner.sv
// Scans one register across every PE of the array and queues the results
// in a small show-ahead FIFO, issuing reads only when FIFO space is assured.
module pe_readout_scanner #(
    parameter int SIZE   = 5,
    parameter int LENGTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_start,
    input  logic [9:0]            scan_reg,
    output logic [SIZE-1:0]       PE_Addr,
    output logic [9:0]            RegAddr,
    input  logic [15:0]           data,
    output logic                  busy,
    output logic                  done,
    pe_readout_scanner_if.master  out_bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE-1:0] LAST = SIZE'(LENGTH - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t          state;
    logic            inflight;
    logic [AW:0]     count;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [15:0]     mem_data [DEPTH];
    logic [SIZE-1:0] mem_pe [DEPTH];

    logic            push;
    logic            pop;
    logic            issue;
    logic [AW:0]     count_next;

    // A read issued now lands next edge; only issue if it is sure to fit.
    assign push       = inflight;
    assign pop        = out_bus.out_valid && out_bus.out_ready;
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);
    assign issue      = (state == SCAN) && (count_next < FULL);

    assign out_bus.out_valid = (count != '0);
    assign out_bus.out_data  = mem_data[rp];
    assign out_bus.out_pe    = mem_pe[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            PE_Addr  <= '0;
            RegAddr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (scan_start) begin
                        RegAddr  <= scan_reg;
                        PE_Addr  <= '0;
                        busy     <= 1'b1;
                        inflight <= 1'b1;
                        state    <= (LENGTH == 1) ? DRAIN : SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        PE_Addr  <= PE_Addr + 1'b1;
                        inflight <= 1'b1;
                        if (PE_Addr + 1'b1 == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pe[i]   <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wp] <= data;
                mem_pe[wp]   <= PE_Addr;
                wp           <= (wp == TOP) ? '0 : wp + 1'b1;
            end
            if (pop) begin
                rp <= (rp == TOP) ? '0 : rp + 1'b1;
            end
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_pe_readout_scanner.sv
// Directed bench for pe_readout_scanner: full scan, backpressure,
// ignored requests, mid-scan reset and FIFO pointer wrap.
module tb_pe_readout_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_start = 1'b0;
    logic [9:0]  scan_reg = 10'h000;
    logic [4:0]  PE_Addr;
    logic [9:0]  RegAddr;
    logic [15:0] data;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    int beats;
    int dones;
    int maxcnt;
    bit found;

    pe_readout_scanner_if #(.SIZE(5)) ob ();

    pe_readout_scanner #(
        .SIZE(5),
        .LENGTH(32),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_start(scan_start),
        .scan_reg(scan_reg),
        .PE_Addr(PE_Addr),
        .RegAddr(RegAddr),
        .data(data),
        .busy(busy),
        .done(done),
        .out_bus(ob)
    );

    always #5 clk = ~clk;

    // Array Top model: data seen at an edge reflects last cycle's address
    assign data = 16'h0100 | {11'd0, PE_Addr};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic rdy);
        @(negedge clk);
        scan_reg     = 10'h020;
        scan_start   = 1'b1;
        ob.out_ready = rdy;
        @(negedge clk);
        scan_start = 1'b0;
    endtask

    // mode 0: ready held; 1: toggling; 2: held low until hold;
    // 3: ready held with stray scan_start/scan_reg mid-scan
    task automatic stream(input int mode, input int hold, output int nb,
                          output int nd, output int mc);
        int after;
        after = -1;
        nb = 0;
        nd = 0;
        mc = 0;
        for (int c = 0; c < 400; c++) begin
            case (mode)
                1: ob.out_ready = ~c[0];
                2: ob.out_ready = (c >= hold);
                default: ob.out_ready = 1'b1;
            endcase
            if (mode == 3) begin
                scan_start = (c == 5 || c == 6);
                scan_reg   = (c >= 5) ? 10'h3FF : 10'h020;
            end
            if (mode == 2 && c == hold - 1) begin
                check("stall_pe_addr", 32'(PE_Addr), 3);
                check("stall_count", 32'(dut.count), 4);
                check("stall_head_pe", 32'(ob.out_pe), 0);
                check("stall_valid", 32'(ob.out_valid), 1);
            end
            if (mode == 3 && c == 8) begin
                check("ignore_regaddr", 32'(RegAddr), 32'h020);
            end
            if (int'(dut.count) > mc) mc = int'(dut.count);
            if (ob.out_valid && ob.out_ready) begin
                check($sformatf("beat%0d_pe", nb), 32'(ob.out_pe), nb);
                check($sformatf("beat%0d_data", nb), 32'(ob.out_data),
                      32'h0100 + nb);
                nb++;
            end
            if (done) begin
                nd++;
                if (after < 0) after = c;
            end
            if (after >= 0 && c == after + 3) break;
            @(negedge clk);
        end
        if (after < 0) check("done_timeout", 0, 1);
        scan_start = 1'b0;
        scan_reg   = 10'h020;
    endtask

    task automatic finish_checks(input string tag);
        check({tag, "_beats"}, beats, 32);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_valid_after"}, 32'(ob.out_valid), 0);
        check({tag, "_count_after"}, 32'(dut.count), 0);
    endtask

    initial begin
        ob.out_ready = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pe_addr", 32'(PE_Addr), 0);
        check("rst_regaddr", 32'(RegAddr), 0);
        check("rst_valid", 32'(ob.out_valid), 0);
        check("rst_out_data", 32'(ob.out_data), 0);
        check("rst_out_pe", 32'(ob.out_pe), 0);
        check("rst_count", 32'(dut.count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Full scan with ready held high
        start(1'b1);
        check("full_busy", 32'(busy), 1);
        check("full_regaddr", 32'(RegAddr), 32'h020);
        check("full_pe_addr0", 32'(PE_Addr), 0);
        check("full_valid_edge1", 32'(ob.out_valid), 0);
        @(negedge clk);
        check("full_valid_edge2", 32'(ob.out_valid), 1);
        check("full_first_pe", 32'(ob.out_pe), 0);
        stream(0, 0, beats, dones, maxcnt);
        finish_checks("full");
        check("full_regaddr_end", 32'(RegAddr), 32'h020);

        // Backpressure from the start
        start(1'b0);
        stream(2, 10, beats, dones, maxcnt);
        finish_checks("bp");

        // Stray requests during a busy scan
        start(1'b1);
        stream(3, 0, beats, dones, maxcnt);
        finish_checks("ign");
        check("ign_regaddr_end", 32'(RegAddr), 32'h020);

        // Reset in the middle of a scan
        start(1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (PE_Addr == 5'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_reach_pe10", 32'(found), 1);
        reset = 1'b0;
        #1;
        check("mid_valid", 32'(ob.out_valid), 0);
        check("mid_count", 32'(dut.count), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_pe_addr", 32'(PE_Addr), 0);
        check("mid_regaddr", 32'(RegAddr), 0);
        check("mid_out_pe", 32'(ob.out_pe), 0);
        @(negedge clk);
        reset = 1'b1;
        start(1'b1);
        @(negedge clk);
        check("restart_valid", 32'(ob.out_valid), 1);
        check("restart_pe", 32'(ob.out_pe), 0);
        stream(0, 0, beats, dones, maxcnt);
        finish_checks("restart");

        // Toggling ready wraps the FIFO pointers repeatedly
        start(1'b1);
        stream(1, 0, beats, dones, maxcnt);
        finish_checks("wrap");
        check("wrap_maxcnt_le4", 32'(maxcnt <= 4), 1);
        check("wrap_wp", 32'(dut.wp), 0);
        check("wrap_rp", 32'(dut.rp), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
